// File: rtl/mem_port_sequencer.sv
// mem_port_sequencer
// Arbitrates a write channel and a read channel onto one single-port
// synchronous RAM (read-old-data, q valid one cycle after the address).
// Read data returns through a 3-entry response FIFO. A credit count of
// reads in flight plus queued responses keeps that FIFO from overflowing.
//
// Optional feature: define MEM_INIT_SWEEP_EN to write zero to every RAM
// address after each reset release, with busy high, before any request
// is accepted. Without the macro the block runs as soon as reset releases
// and busy is tied low.
module mem_port_sequencer #(
    parameter int ADDR_BITS = 8,
    parameter int DATA_BITS = 16
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 wr_valid,
    output logic                 wr_ready,
    input  logic [ADDR_BITS-1:0] wr_addr,
    input  logic [DATA_BITS-1:0] wr_data,
    input  logic                 rd_valid,
    output logic                 rd_ready,
    input  logic [ADDR_BITS-1:0] rd_addr,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [DATA_BITS-1:0] rsp_data,
    output logic [ADDR_BITS-1:0] ram_a,
    output logic                 ram_we,
    output logic [DATA_BITS-1:0] ram_d,
    input  logic [DATA_BITS-1:0] ram_q,
    output logic                 busy
);

    localparam int FIFO_DEPTH = 3;

    // run: requests may be granted; sweeping: the zero-fill owns the RAM.
    // Both are gated by resetn so the channels and the RAM write enable
    // are quiet for as long as reset is held, not just after the next edge.
    logic                 run;
    logic                 sweeping;
    logic [ADDR_BITS-1:0] sweep_addr;

`ifdef MEM_INIT_SWEEP_EN
    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [ADDR_BITS-1:0] sweep_addr_next;

    // State register and sweep address; reset mid-sweep restarts at 0
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values of the others, whatever the block order.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= ST_INIT;
            sweep_addr <= '0;
        end else begin
            state      <= state_next;
            sweep_addr <= sweep_addr_next;
        end
    end

    // Next state: one address per cycle, leave INIT after the last one
    // NOTE: every signal written here gets a default first, so no path
    // through the block leaves it unassigned and no latch is inferred.
    always_comb begin
        state_next      = state;
        sweep_addr_next = sweep_addr;
        case (state)
            ST_INIT: begin
                sweep_addr_next = sweep_addr + 1'b1;
                if (sweep_addr == '1) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                state_next = ST_RUN;
            end
        endcase
    end

    assign sweeping = resetn && (state == ST_INIT);
    assign run      = resetn && (state == ST_RUN);
`else
    assign sweeping   = 1'b0;
    assign sweep_addr = '0;
    assign run        = resetn;
`endif

    assign busy = sweeping;

    // ------------------------------------------------------------------
    // Credits and arbitration
    // ------------------------------------------------------------------
    logic       rd_inflight;   // a read was granted last cycle; q arrives now
    logic [1:0] fifo_cnt;      // queued responses, 0..3
    logic [1:0] credit;        // rd_inflight + fifo_cnt, never above 3
    logic       rd_has_credit;
    logic       wr_prio;       // write wins the next contention
    logic       contention;
    logic       wr_grant;
    logic       rd_grant;

    // Credit comes only from registers, so rsp_ready never reaches rd_ready
    // combinationally; a pop frees its credit one cycle later.
    assign credit        = fifo_cnt + {1'b0, rd_inflight};
    assign rd_has_credit = (credit != 2'd3);

    // A channel is ready unless the other channel is competing and holds
    // the priority. Contention only counts when the read is eligible.
    assign contention = run && wr_valid && rd_valid && rd_has_credit;
    assign wr_ready   = run && !(rd_valid && rd_has_credit && !wr_prio);
    assign rd_ready   = run && rd_has_credit && !(wr_valid && wr_prio);
    assign wr_grant   = wr_valid && wr_ready;
    assign rd_grant   = rd_valid && rd_ready;

    // Round-robin: the winner of a contention loses the next one
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_prio <= 1'b1;
        end else if (contention) begin
            wr_prio <= !wr_prio;
        end
    end

    // RAM port driven straight from the sweep or the granted request
    always_comb begin
        ram_we = 1'b0;
        ram_a  = '0;
        ram_d  = '0;
        if (sweeping) begin
            ram_we = 1'b1;
            ram_a  = sweep_addr;
        end else if (wr_grant) begin
            ram_we = 1'b1;
            ram_a  = wr_addr;
            ram_d  = wr_data;
        end else if (rd_grant) begin
            ram_a  = rd_addr;
        end
    end

    // Track the read whose data shows up on ram_q next cycle
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_inflight <= 1'b0;
        end else begin
            rd_inflight <= rd_grant;
        end
    end

    // ------------------------------------------------------------------
    // Response FIFO (3 entries, pointers wrap modulo 3)
    // ------------------------------------------------------------------
    logic [DATA_BITS-1:0] fifo_mem [FIFO_DEPTH];
    logic [1:0]           wr_ptr;
    logic [1:0]           rd_ptr;
    logic                 push;
    logic                 pop;

    function automatic logic [1:0] ptr_inc(input logic [1:0] ptr);
        return (ptr == 2'(FIFO_DEPTH - 1)) ? 2'd0 : ptr + 2'd1;
    endfunction

    // The credit limit guarantees a slot for every in-flight read, so a
    // push never meets a full FIFO.
    assign push      = rd_inflight;
    assign pop       = rsp_valid && rsp_ready;
    assign rsp_valid = (fifo_cnt != 2'd0);
    assign rsp_data  = fifo_mem[rd_ptr];

    // Capture returning RAM data into the slot at the write pointer
    // NOTE: the storage array has no reset; emptiness is carried by the
    // reset count and pointers, so stale words are never presented.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= ram_q;
        end
    end

    // Pointers and occupancy; simultaneous push and pop leave count alone
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr   <= 2'd0;
            rd_ptr   <= 2'd0;
            fifo_cnt <= 2'd0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
                2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_sequencer.sv
// Testbench for mem_port_sequencer: a behavioural RAM on the RAM port, and a
// reference model that predicts grants from the arbitration rules and
// responses as a queue of (data, cycle it becomes visible).
// Build with MEM_INIT_SWEEP_EN defined to also exercise the zero-fill sweep.
module tb_mem_port_sequencer;

    localparam int AB    = 8;
    localparam int DB    = 16;
    localparam int NADDR = 1 << AB;

    logic          clk = 1'b0;
    logic          resetn;
    logic          wr_valid, wr_ready, rd_valid, rd_ready;
    logic          rsp_valid, rsp_ready, ram_we, busy;
    logic [AB-1:0] wr_addr, rd_addr, ram_a;
    logic [DB-1:0] wr_data, rsp_data, ram_d, ram_q;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Reference model state
    typedef struct {
        logic [DB-1:0] data;
        int            due;
    } rsp_t;

    rsp_t          exp_q[$];
    logic [DB-1:0] m_mem [NADDR] = '{default: '0};
    bit            m_last_rd_won = 1'b1;

    // Observed handshakes of the most recent cycle, for the scenario tasks
    bit            g_wr, g_rd, g_rsp;
    logic [DB-1:0] g_rsp_data;

    always #5 clk = ~clk;

    mem_port_sequencer #(.ADDR_BITS(AB), .DATA_BITS(DB)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rd_addr   (rd_addr),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .ram_a     (ram_a),
        .ram_we    (ram_we),
        .ram_d     (ram_d),
        .ram_q     (ram_q),
        .busy      (busy)
    );

    // Single-port synchronous RAM, read-old-data
    logic [DB-1:0] ram [NADDR] = '{default: '0};
    always @(posedge clk) begin
        if (ram_we === 1'b1) ram[ram_a] <= ram_d;
        ram_q <= ram[ram_a];
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1);
    end

    // One clock cycle with the inputs the caller set; compares the DUT
    // against the model at the negedge, then advances the model.
    task automatic run_cycle();
        bit            rd_can, both, e_wr, e_rd, e_rv;
        logic [AB-1:0] e_a;
        logic [DB-1:0] e_d;
        rsp_t          ent;
        @(negedge clk);
        rd_can = (exp_q.size() < 3);
        both   = wr_valid && rd_valid && rd_can;
        if (both) begin
            e_wr = m_last_rd_won;
            e_rd = !m_last_rd_won;
        end else begin
            e_wr = wr_valid;
            e_rd = rd_valid && rd_can;
        end
        e_a  = e_wr ? wr_addr : (e_rd ? rd_addr : '0);
        e_d  = e_wr ? wr_data : '0;
        e_rv = (exp_q.size() > 0) && (exp_q[0].due <= cyc);

        checks++;
        if ((wr_valid && wr_ready) !== e_wr) begin
            failures++;
            $display("FAIL wr_grant cyc=%0d: got %0b expected %0b", cyc, wr_valid && wr_ready, e_wr);
        end
        checks++;
        if ((rd_valid && rd_ready) !== e_rd) begin
            failures++;
            $display("FAIL rd_grant cyc=%0d: got %0b expected %0b", cyc, rd_valid && rd_ready, e_rd);
        end
        checks++;
        if (ram_we !== e_wr) begin
            failures++;
            $display("FAIL ram_we cyc=%0d: got %0b expected %0b", cyc, ram_we, e_wr);
        end
        checks++;
        if (ram_a !== e_a) begin
            failures++;
            $display("FAIL ram_a cyc=%0d: got %0h expected %0h", cyc, ram_a, e_a);
        end
        if (!e_rd) begin
            checks++;
            if (ram_d !== e_d) begin
                failures++;
                $display("FAIL ram_d cyc=%0d: got %0h expected %0h", cyc, ram_d, e_d);
            end
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL busy_run cyc=%0d: got %0b expected 0", cyc, busy);
        end
        checks++;
        if (rsp_valid !== e_rv) begin
            failures++;
            $display("FAIL rsp_valid cyc=%0d: got %0b expected %0b", cyc, rsp_valid, e_rv);
        end
        if (e_rv) begin
            checks++;
            if (rsp_data !== exp_q[0].data) begin
                failures++;
                $display("FAIL rsp_data cyc=%0d: got %0h expected %0h", cyc, rsp_data, exp_q[0].data);
            end
        end

        g_wr       = wr_valid && wr_ready;
        g_rd       = rd_valid && rd_ready;
        g_rsp      = rsp_valid && rsp_ready;
        g_rsp_data = rsp_data;

        if (e_wr) m_mem[wr_addr] = wr_data;
        if (both) m_last_rd_won = e_rd;
        if (e_rd) begin
            ent.data = m_mem[rd_addr];
            ent.due  = cyc + 2;
            exp_q.push_back(ent);
        end
        if (e_rv && rsp_ready) void'(exp_q.pop_front());

        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Assert reset with requests pending, check the quiet outputs, release,
    // and (with the sweep) follow sweep_cycles cycles of the zero-fill.
    task automatic do_reset(input int sweep_cycles);
        resetn   = 1'b0;
        wr_valid = 1'b1;
        rd_valid = 1'b1;
        wr_addr  = AB'($urandom);
        rd_addr  = AB'($urandom);
        wr_data  = DB'($urandom);
        rsp_ready = 1'b1;
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || wr_ready !== 1'b0 || rd_ready !== 1'b0 || ram_we !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: rsp_valid=%b wr_ready=%b rd_ready=%b ram_we=%b expected all 0",
                     rsp_valid, wr_ready, rd_ready, ram_we);
        end
        repeat (2) @(posedge clk);
        #1;
        exp_q.delete();
        m_last_rd_won = 1'b1;
        wr_valid = 1'b0;
        rd_valid = 1'b0;
`ifdef MEM_INIT_SWEEP_EN
        wr_valid = 1'b1;
        rd_valid = 1'b1;
`endif
        resetn = 1'b1;
        #1;
`ifdef MEM_INIT_SWEEP_EN
        for (int k = 0; k < sweep_cycles; k++) begin
            checks++;
            if (busy !== 1'b1 || ram_we !== 1'b1 || ram_a !== AB'(k) || ram_d !== '0 ||
                wr_ready !== 1'b0 || rd_ready !== 1'b0) begin
                failures++;
                $display("FAIL sweep k=%0d: busy=%b ram_we=%b ram_a=%0h ram_d=%0h rdy=%b%b expected 1 1 %0h 0 00",
                         k, busy, ram_we, ram_a, ram_d, wr_ready, rd_ready, AB'(k));
            end
            @(posedge clk);
            #1;
        end
        if (sweep_cycles >= NADDR) begin
            for (int i = 0; i < NADDR; i++) m_mem[i] = '0;
            checks++;
            if (busy !== 1'b0) begin
                failures++;
                $display("FAIL sweep_end: busy=%b expected 0", busy);
            end
        end
        wr_valid = 1'b0;
        rd_valid = 1'b0;
`else
        checks++;
        if (busy !== 1'b0 || wr_ready !== 1'b1) begin
            failures++;
            $display("FAIL run_after_reset: busy=%b wr_ready=%b expected 0 1", busy, wr_ready);
        end
`endif
    endtask

    task automatic test_reset();
        do_reset(NADDR);
        run_cycle();
        checks++;
        if (rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle_rsp: got %b expected 0", rsp_valid);
        end
    endtask

`ifdef MEM_INIT_SWEEP_EN
    task automatic test_sweep_restart();
        do_reset(40);
        do_reset(NADDR);
        rd_valid  = 1'b1;
        rd_addr   = 8'hFF;
        rsp_ready = 1'b1;
        run_cycle();
        rd_valid = 1'b0;
        run_cycle();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== 16'h0000) begin
            failures++;
            $display("FAIL read_ff_after_sweep: valid=%b data=%0h expected 1 0000", rsp_valid, rsp_data);
        end
        run_cycle();
    endtask
`endif

    task automatic test_write_then_read();
        rsp_ready = 1'b1;
        wr_valid  = 1'b1;
        wr_addr   = 8'h05;
        wr_data   = 16'h1234;
        run_cycle();
        wr_valid = 1'b0;
        rd_valid = 1'b1;
        rd_addr  = 8'h05;
        run_cycle();
        rd_valid = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL raw_early: rsp_valid=%b expected 0 at N+2", rsp_valid);
        end
        run_cycle();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== 16'h1234) begin
            failures++;
            $display("FAIL raw_data: valid=%b data=%0h expected 1 1234 at N+3", rsp_valid, rsp_data);
        end
        run_cycle();
    endtask

    task automatic test_stream();
        int n_rsp = 0, first = -1, last = -1, n_rd = 0;
        rsp_ready = 1'b1;
        wr_valid  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            wr_addr = AB'(i);
            wr_data = DB'(16'hA000 + i);
            run_cycle();
        end
        wr_valid = 1'b0;
        rd_valid = 1'b1;
        for (int i = 0; i < 22; i++) begin
            rd_addr = AB'(i);
            if (i == 10) rd_valid = 1'b0;
            run_cycle();
            if (g_rd) n_rd++;
            if (g_rsp) begin
                checks++;
                if (g_rsp_data !== DB'(16'hA000 + n_rsp)) begin
                    failures++;
                    $display("FAIL stream_order: got %0h expected %0h", g_rsp_data, DB'(16'hA000 + n_rsp));
                end
                if (first < 0) first = i;
                last = i;
                n_rsp++;
            end
        end
        checks++;
        if (n_rd !== 10 || n_rsp !== 10 || (last - first) !== 9) begin
            failures++;
            $display("FAIL stream: reads=%0d rsps=%0d span=%0d expected 10 10 9", n_rd, n_rsp, last - first);
        end
    endtask

    task automatic test_backpressure();
        int n_rd = 0, n_rsp = 0;
        rsp_ready = 1'b0;
        rd_valid  = 1'b1;
        for (int i = 0; i < 6; i++) begin
            rd_addr = AB'(i);
            run_cycle();
            if (g_rd) n_rd++;
        end
        checks++;
        if (n_rd !== 3 || rd_ready !== 1'b0) begin
            failures++;
            $display("FAIL credit_limit: reads=%0d rd_ready=%b expected 3 0", n_rd, rd_ready);
        end
        rsp_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            rd_addr = AB'(i + 3);
            run_cycle();
            if (g_rd) n_rd++;
            if (g_rsp) begin
                checks++;
                if (n_rsp < 3 && g_rsp_data !== DB'(16'hA000 + n_rsp)) begin
                    failures++;
                    $display("FAIL drain_order: got %0h expected %0h", g_rsp_data, DB'(16'hA000 + n_rsp));
                end
                n_rsp++;
            end
        end
        checks++;
        if (n_rsp < 3 || n_rd <= 3) begin
            failures++;
            $display("FAIL resume: rsps=%0d reads=%0d expected >=3 and >3", n_rsp, n_rd);
        end
        rd_valid = 1'b0;
        repeat (4) run_cycle();
    endtask

    task automatic test_alternate();
        do_reset(NADDR);
        rsp_ready = 1'b1;
        wr_valid  = 1'b1;
        rd_valid  = 1'b1;
        for (int i = 0; i < 8; i++) begin
            wr_addr = AB'($urandom_range(0, 7));
            rd_addr = AB'($urandom_range(0, 7));
            wr_data = DB'($urandom);
            run_cycle();
            checks++;
            if (g_wr !== ((i % 2) == 0) || g_rd !== ((i % 2) == 1)) begin
                failures++;
                $display("FAIL alternate i=%0d: wr=%b rd=%b expected wr=%b", i, g_wr, g_rd, (i % 2) == 0);
            end
        end
        wr_valid = 1'b0;
        rd_valid = 1'b0;
        repeat (3) run_cycle();
    endtask

    task automatic test_reset_flush();
        int n_rsp = 0;
        rsp_ready = 1'b0;
        rd_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rd_addr = AB'(i);
            run_cycle();
        end
        rd_valid = 1'b0;
        checks++;
        if (rsp_valid !== 1'b1) begin
            failures++;
            $display("FAIL flush_setup: rsp_valid=%b expected 1", rsp_valid);
        end
        do_reset(NADDR);
        rsp_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            run_cycle();
            if (g_rsp) n_rsp++;
        end
        checks++;
        if (n_rsp !== 0) begin
            failures++;
            $display("FAIL stale_rsp: got %0d responses expected 0", n_rsp);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 800; i++) begin
            wr_valid  = ($urandom_range(0, 99) < 45);
            rd_valid  = ($urandom_range(0, 99) < 55);
            wr_addr   = AB'($urandom_range(0, 7));
            rd_addr   = AB'($urandom_range(0, 7));
            wr_data   = DB'($urandom);
            rsp_ready = ($urandom_range(0, 99) < 65);
            run_cycle();
        end
        wr_valid  = 1'b0;
        rd_valid  = 1'b0;
        rsp_ready = 1'b1;
        repeat (6) run_cycle();
        checks++;
        if (rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL random_drain: rsp_valid=%b expected 0", rsp_valid);
        end
    endtask

    initial begin
        resetn    = 1'b0;
        wr_valid  = 1'b0;
        rd_valid  = 1'b0;
        rsp_ready = 1'b0;
        wr_addr   = '0;
        rd_addr   = '0;
        wr_data   = '0;
        @(posedge clk);
        #1;
        test_reset();
`ifdef MEM_INIT_SWEEP_EN
        test_sweep_restart();
`endif
        test_write_then_read();
        test_stream();
        test_backpressure();
        test_alternate();
        test_reset_flush();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_port_sequencer.md
MEM_PORT_SEQUENCER -- requirements
Module: mem_port_sequencer

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 8, memory address width.
REQ-002 SHALL have parameter DATA_BITS, default 16, memory word width.
REQ-003 SHALL have port clk  in  1  sole clock; all state updates on posedge.
REQ-004 SHALL have port resetn  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports wr_valid in 1, wr_ready out 1, wr_addr in ADDR_BITS, wr_data in DATA_BITS: write request channel.
REQ-006 SHALL have ports rd_valid in 1, rd_ready out 1, rd_addr in ADDR_BITS: read request channel.
REQ-007 SHALL have ports rsp_valid out 1, rsp_ready in 1, rsp_data out DATA_BITS: read response channel.
REQ-008 SHALL have ports ram_a out ADDR_BITS, ram_we out 1, ram_d out DATA_BITS, ram_q in DATA_BITS: single-port synchronous RAM (address sampled at posedge, q valid the following cycle, read-old-data).
REQ-009 SHALL have port busy  out  1  high while initialisation sweep runs.

Function
REQ-010 SHALL transfer on any channel only in a cycle where valid and ready are both high.
REQ-011 SHALL grant at most one request per cycle; ram_a/ram_we/ram_d combinational from the granted request.
REQ-012 SHALL, when wr and rd both valid and both eligible, grant round-robin: grant the channel not granted at the last contention; after reset, write wins first.
REQ-013 SHALL drive ram_we=1, ram_a=wr_addr, ram_d=wr_data on write grant; ram_we=0 otherwise; ram_a=rd_addr on read grant; ram_a=0, ram_d=0 when idle.
REQ-014 SHALL capture ram_q, one cycle after a read grant, into a 3-entry response FIFO; read handshake in cycle N gives rsp_valid earliest in cycle N+2.
REQ-015 SHALL keep credit count = reads in flight + FIFO occupancy (0..3); rd eligible only when count<3; no combinational path rsp_ready->rd_ready.
REQ-016 SHALL sustain one read per cycle when rsp_ready is held high (steady-state count 2).
REQ-017 SHALL hold rsp_data stable while rsp_valid=1 and rsp_ready=0; responses in request order.
REQ-018 SHALL return new data for a read granted the cycle after a write to the same address.
REQ-019 SHALL update credit count correctly when read grant and response pop occur in the same cycle (net zero).
REQ-020 SHALL wrap FIFO pointers modulo 3 with no loss or duplication.

Reset
REQ-021 SHALL, on resetn low, immediately clear: rsp_valid=0, credit count=0, FIFO pointers=0, round-robin state=write-first, in-flight flag=0.
REQ-022 SHALL discard any in-flight read and queued responses on reset; RAM contents untouched except by sweep (REQ-024).
REQ-023 SHALL hold wr_ready=rd_ready=0 and ram_we=0 while resetn is low.

Configuration
REQ-024 SHALL, with macro MEM_INIT_SWEEP_EN defined, enter state INIT after reset release: write 0 to addresses 0..2^ADDR_BITS-1 one per cycle, busy=1, wr_ready=rd_ready=0, then enter RUN with busy=0.
REQ-025 SHALL, with MEM_INIT_SWEEP_EN defined, restart the sweep at address 0 if reset asserts mid-sweep.
REQ-026 SHALL, without MEM_INIT_SWEEP_EN, enter RUN directly after reset release and tie busy=0.

Verification
REQ-027 Write 0x1234 to 0x05 (cycle N), read 0x05 (cycle N+1), rsp_ready=1 -> rsp_valid and rsp_data=0x1234 in cycle N+3.
REQ-028 rd_valid held high 10 cycles, addresses 0..9, rsp_ready=1 -> 10 responses on consecutive cycles, in order, rd_ready never low after first grant.
REQ-029 rsp_ready=0, rd_valid held -> exactly 3 reads accepted, rd_ready low; raise rsp_ready -> 3 responses in order, then reads resume.
REQ-030 wr_valid and rd_valid held continuously -> grants alternate W,R,W,R from first contention cycle.
REQ-031 With MEM_INIT_SWEEP_EN, release reset -> busy high 256 cycles, ram_we=1 and ram_d=0 for addresses 0..255, then read 0xFF returns 0x0000.
REQ-032 Assert resetn low with 2 responses queued and 1 in flight -> rsp_valid=0 immediately; after release no stale response appears.
